// File: rtl/wb_arbiter_mux.sv
// Writeback stage: selects the W-stage result, merges long-latency (div/mul)
// results through a small FIFO and drives the single registered regfile write port.
module wb_arbiter_mux #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned RW    = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_valid_W,
    input  logic                         RegWriteW,
    input  logic [1:0]                   ResultSrcW,
    input  logic [2:0]                   funct3W,
    input  logic [XLEN-1:0]              ALUResult_W,
    input  logic [XLEN-1:0]              read_data_W,
    input  logic [XLEN-1:0]              PCplus4W,
    input  logic [XLEN-1:0]              csr_rdata_W,
    input  logic [RW-1:0]                rdW,
    input  logic                         ll_valid,
    output logic                         ll_ready,
    input  logic [RW-1:0]                ll_rd,
    input  logic [XLEN-1:0]              ll_data,
    output logic                         rf_we,
    output logic [RW-1:0]                rf_rd,
    output logic [XLEN-1:0]              rf_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   buf_count,
    output logic [7:0]                   drop_count
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // FIFO storage; occ marks live slots, sq marks slots killed by a younger write
    logic [RW-1:0]   buf_rd   [DEPTH];
    logic [XLEN-1:0] buf_data [DEPTH];
    logic [DEPTH-1:0] occ;
    logic [DEPTH-1:0] sq;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;

    logic [XLEN-1:0] shifted;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_result;
    logic [XLEN-1:0] w_result;

    logic            p, a, full, empty, pop, bypass, ll_zero, ll_disc, push;
    logic [DEPTH-1:0] sq_hit;
    int unsigned     n_drop;
    logic [15:0]     drop_sum;
    logic [7:0]      drop_next;
    logic [PW-1:0]   head_nx;
    logic [PW-1:0]   tail_nx;

    // W-stage result selection including load sign/zero extension
    always_comb begin
        shifted = read_data_W >> {ALUResult_W[1:0], 3'b000};
        ld_byte = shifted[7:0];
        ld_half = ALUResult_W[1] ? read_data_W[31:16] : read_data_W[15:0];
        case (funct3W)
            3'b000:  ld_result = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_result = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  ld_result = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_result = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_result = read_data_W;
        endcase
        case (ResultSrcW)
            2'b00:   w_result = ALUResult_W;
            2'b01:   w_result = ld_result;
            2'b10:   w_result = PCplus4W;
            default: w_result = csr_rdata_W;
        endcase
    end

    assign full     = (buf_count == CW'(DEPTH));
    assign empty    = (buf_count == '0);
    assign ll_ready = !full;

    // Arbitration, squash detection and drop accounting
    always_comb begin
        p       = wb_valid_W & RegWriteW & (rdW != '0);
        a       = ll_valid & ll_ready;
        pop     = !p && !empty;
        bypass  = !p && empty && a;
        ll_zero = (ll_rd == '0);
        ll_disc = a && p && (ll_rd == rdW);
        push    = a && !bypass && !ll_zero && !ll_disc;
        n_drop  = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            sq_hit[i] = p && occ[i] && !sq[i] && (buf_rd[i] == rdW);
            if (sq_hit[i]) n_drop++;
        end
        if (ll_disc) n_drop++;
        drop_sum  = 16'(drop_count) + 16'(n_drop);
        drop_next = (drop_sum > 16'd255) ? 8'd255 : drop_sum[7:0];
        head_nx   = (head == PW'(DEPTH - 1)) ? '0 : head + 1'b1;
        tail_nx   = (tail == PW'(DEPTH - 1)) ? '0 : tail + 1'b1;
    end

    // Registered write port and FIFO state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_rd      <= '0;
            rf_wdata   <= '0;
            buf_count  <= '0;
            drop_count <= '0;
            head       <= '0;
            tail       <= '0;
            occ        <= '0;
            sq         <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_rd[i]   <= '0;
                buf_data[i] <= '0;
            end
        end else begin
            if (p) begin
                rf_we    <= 1'b1;
                rf_rd    <= rdW;
                rf_wdata <= w_result;
            end else if (pop) begin
                rf_we <= !sq[head];
                if (!sq[head]) begin
                    rf_rd    <= buf_rd[head];
                    rf_wdata <= buf_data[head];
                end
            end else if (bypass && !ll_zero) begin
                rf_we    <= 1'b1;
                rf_rd    <= ll_rd;
                rf_wdata <= ll_data;
            end else begin
                rf_we <= 1'b0;
            end

            for (int i = 0; i < int'(DEPTH); i++) begin
                if (sq_hit[i]) sq[i] <= 1'b1;
            end
            if (pop) begin
                occ[head] <= 1'b0;
                head      <= head_nx;
            end
            if (push) begin
                occ[tail]      <= 1'b1;
                sq[tail]       <= 1'b0;
                buf_rd[tail]   <= ll_rd;
                buf_data[tail] <= ll_data;
                tail           <= tail_nx;
            end
            buf_count  <= buf_count + CW'(push) - CW'(pop);
            drop_count <= drop_next;
        end
    end
endmodule

// File: tb/tb_wb_arbiter_mux.sv
// Directed bench for wb_arbiter_mux (XLEN=32, DEPTH=2, RW=5).
module tb_wb_arbiter_mux;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid_W, RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [2:0]  funct3W;
    logic [31:0] ALUResult_W, read_data_W, PCplus4W, csr_rdata_W;
    logic [4:0]  rdW;
    logic        ll_valid, ll_ready;
    logic [4:0]  ll_rd;
    logic [31:0] ll_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [1:0]  buf_count;
    logic [7:0]  drop_count;

    int n_pass  = 0;
    int n_total = 0;

    wb_arbiter_mux #(.XLEN(32), .DEPTH(2), .RW(5)) dut (
        .clk(clk), .rst(rst),
        .wb_valid_W(wb_valid_W), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .funct3W(funct3W), .ALUResult_W(ALUResult_W), .read_data_W(read_data_W),
        .PCplus4W(PCplus4W), .csr_rdata_W(csr_rdata_W), .rdW(rdW),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .buf_count(buf_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input logic v, input logic [1:0] src, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [4:0] rd);
        wb_valid_W  = v;
        RegWriteW   = v;
        ResultSrcW  = src;
        funct3W     = f3;
        ALUResult_W = alu;
        rdW         = rd;
    endtask

    task automatic set_ll(input logic v, input logic [4:0] rd, input logic [31:0] d);
        ll_valid = v;
        ll_rd    = rd;
        ll_data  = d;
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, "_we"}, 32'(rf_we), 32'(we));
        chk({tag, "_rd"}, 32'(rf_rd), 32'(rd));
        chk({tag, "_wdata"}, rf_wdata, d);
    endtask

    initial begin
        rst = 1'b1;
        set_w(1'b0, 2'b00, 3'b000, 32'h0, 5'd0);
        read_data_W = 32'h0;
        PCplus4W    = 32'h0;
        csr_rdata_W = 32'h0;
        set_ll(1'b0, 5'd0, 32'h0);
        step();
        step();
        chk_rf("reset", 1'b0, 5'd0, 32'h0);
        chk("reset_buf", 32'(buf_count), 32'd0);
        chk("reset_drop", 32'(drop_count), 32'd0);
        chk("reset_ready", 32'(ll_ready), 32'd1);
        rst = 1'b0;

        // loads
        read_data_W = 32'h80123456;
        set_w(1'b1, 2'b01, 3'b000, 32'h3, 5'd4); step(); chk_rf("lb", 1'b1, 5'd4, 32'hFFFFFF80);
        set_w(1'b1, 2'b01, 3'b100, 32'h3, 5'd4); step(); chk_rf("lbu", 1'b1, 5'd4, 32'h00000080);
        set_w(1'b1, 2'b01, 3'b001, 32'h2, 5'd4); step(); chk_rf("lh", 1'b1, 5'd4, 32'hFFFF8012);
        set_w(1'b1, 2'b01, 3'b101, 32'h2, 5'd4); step(); chk_rf("lhu", 1'b1, 5'd4, 32'h00008012);
        set_w(1'b1, 2'b01, 3'b000, 32'h1, 5'd4); step(); chk_rf("lb_off1", 1'b1, 5'd4, 32'h00000034);
        set_w(1'b1, 2'b01, 3'b010, 32'h0, 5'd4); step(); chk_rf("lw", 1'b1, 5'd4, 32'h80123456);
        set_w(1'b1, 2'b01, 3'b011, 32'h0, 5'd4); step(); chk_rf("ld_other", 1'b1, 5'd4, 32'h80123456);

        // PC+4, x0 suppression, CSR, ALU
        PCplus4W = 32'h104;
        set_w(1'b1, 2'b10, 3'b000, 32'h0, 5'd5); step(); chk_rf("pc4", 1'b1, 5'd5, 32'h104);
        set_w(1'b1, 2'b10, 3'b000, 32'h0, 5'd0); step(); chk_rf("pc4_x0", 1'b0, 5'd5, 32'h104);
        csr_rdata_W = 32'hCAFE0001;
        set_w(1'b1, 2'b11, 3'b000, 32'h0, 5'd6); step(); chk_rf("csr", 1'b1, 5'd6, 32'hCAFE0001);
        set_w(1'b1, 2'b00, 3'b000, 32'h1234, 5'd9); step(); chk_rf("alu", 1'b1, 5'd9, 32'h1234);
        set_w(1'b0, 2'b00, 3'b000, 32'h0, 5'd9); step(); chk_rf("idle", 1'b0, 5'd9, 32'h1234);

        // collision: pipeline wins, LL result buffered
        set_w(1'b1, 2'b00, 3'b000, 32'h11, 5'd3);
        set_ll(1'b1, 5'd7, 32'hAA);
        step(); chk_rf("col_p", 1'b1, 5'd3, 32'h11); chk("col_buf1", 32'(buf_count), 32'd1);
        set_w(1'b0, 2'b00, 3'b000, 32'h0, 5'd0);
        set_ll(1'b0, 5'd0, 32'h0);
        step(); chk_rf("col_ll", 1'b1, 5'd7, 32'hAA); chk("col_buf0", 32'(buf_count), 32'd0);

        // backpressure: three LL results against a busy pipeline
        set_w(1'b1, 2'b00, 3'b000, 32'h100, 5'd1); set_ll(1'b1, 5'd10, 32'hA0);
        step(); chk_rf("bp0", 1'b1, 5'd1, 32'h100); chk("bp0_buf", 32'(buf_count), 32'd1);
        chk("bp0_ready", 32'(ll_ready), 32'd1);
        set_w(1'b1, 2'b00, 3'b000, 32'h101, 5'd1); set_ll(1'b1, 5'd11, 32'hA1);
        step(); chk("bp1_buf", 32'(buf_count), 32'd2); chk("bp1_ready", 32'(ll_ready), 32'd0);
        set_w(1'b1, 2'b00, 3'b000, 32'h102, 5'd1); set_ll(1'b1, 5'd12, 32'hA2);
        step(); chk_rf("bp2", 1'b1, 5'd1, 32'h102); chk("bp2_buf", 32'(buf_count), 32'd2);
        chk("bp2_ready", 32'(ll_ready), 32'd0);
        set_w(1'b0, 2'b00, 3'b000, 32'h0, 5'd0);
        step(); chk_rf("bp3", 1'b1, 5'd10, 32'hA0); chk("bp3_buf", 32'(buf_count), 32'd1);
        chk("bp3_ready", 32'(ll_ready), 32'd1);
        step(); chk_rf("bp4", 1'b1, 5'd11, 32'hA1); chk("bp4_buf", 32'(buf_count), 32'd1);
        set_ll(1'b0, 5'd0, 32'h0);
        step(); chk_rf("bp5", 1'b1, 5'd12, 32'hA2); chk("bp5_buf", 32'(buf_count), 32'd0);

        // squash of a buffered entry
        set_w(1'b1, 2'b00, 3'b000, 32'h1, 5'd2); set_ll(1'b1, 5'd7, 32'h55);
        step(); chk("sq_buf1", 32'(buf_count), 32'd1);
        set_ll(1'b0, 5'd0, 32'h0);
        set_w(1'b1, 2'b00, 3'b000, 32'h99, 5'd7);
        step(); chk_rf("sq_p", 1'b1, 5'd7, 32'h99); chk("sq_drop", 32'(drop_count), 32'd1);
        chk("sq_buf_hold", 32'(buf_count), 32'd1);
        set_w(1'b0, 2'b00, 3'b000, 32'h0, 5'd0);
        step(); chk_rf("sq_pop", 1'b0, 5'd7, 32'h99); chk("sq_buf0", 32'(buf_count), 32'd0);

        // LL to x0 is discarded silently; plain bypass
        set_ll(1'b1, 5'd0, 32'h77);
        step(); chk("x0_we", 32'(rf_we), 32'd0); chk("x0_drop", 32'(drop_count), 32'd1);
        chk("x0_buf", 32'(buf_count), 32'd0);
        set_ll(1'b1, 5'd9, 32'h33);
        step(); chk_rf("bypass", 1'b1, 5'd9, 32'h33); chk("bypass_buf", 32'(buf_count), 32'd0);

        // same-cycle LL result to the pipeline's destination is discarded
        set_w(1'b1, 2'b00, 3'b000, 32'h5, 5'd8); set_ll(1'b1, 5'd8, 32'h6);
        step(); chk_rf("disc", 1'b1, 5'd8, 32'h5); chk("disc_drop", 32'(drop_count), 32'd2);
        chk("disc_buf", 32'(buf_count), 32'd0);

        // asynchronous reset with two buffered entries
        set_w(1'b1, 2'b00, 3'b000, 32'h200, 5'd1); set_ll(1'b1, 5'd13, 32'hB0);
        step();
        set_ll(1'b1, 5'd14, 32'hB1);
        step(); chk("rst_pre_buf", 32'(buf_count), 32'd2);
        set_w(1'b0, 2'b00, 3'b000, 32'h0, 5'd0); set_ll(1'b0, 5'd0, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_buf", 32'(buf_count), 32'd0);
        chk("rst_ready", 32'(ll_ready), 32'd1);
        chk("rst_drop", 32'(drop_count), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_we", 32'(rf_we), 32'd0);
            chk("post_rst_buf", 32'(buf_count), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
